// File: rtl/conv_transposed_1d_dilated_stream.sv
// Streaming transposed 1D convolution: each accepted sample is scattered into a
// window of SPAN accumulators, and finished outputs drain through valid/ready.
module conv_transposed_1d_dilated_stream #(
    parameter int DATA_W   = 16,
    parameter int W_W      = 16,
    parameter int ACC_W    = 40,
    parameter int KERNEL   = 3,
    parameter int STRIDE   = 2,
    parameter int DILATION = 2,
    parameter int HAS_BIAS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       out_data,
    output logic                          out_last,
    input  logic                          w_we,
    input  logic [$clog2(KERNEL+1)-1:0]   w_addr,
    input  logic signed [W_W-1:0]         w_data,
    output logic                          busy
);
    localparam int SPAN  = DILATION * (KERNEL - 1) + 1;
    localparam int AW    = $clog2(KERNEL + 1);
    localparam int CNT_W = $clog2(SPAN + 1);
    localparam int P_W   = DATA_W + W_W;
    localparam bit EXACT = (SPAN == STRIDE);

    if (STRIDE > SPAN) begin : g_bad_stride
        $error("STRIDE must not exceed the dilated kernel span");
    end

    typedef enum logic [1:0] {ACCEPT, EMIT, FLUSH} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     last_q;
    logic signed [ACC_W-1:0]  acc_q     [SPAN];
    logic signed [ACC_W-1:0]  acc_d     [SPAN];
    logic signed [ACC_W-1:0]  acc_shift [SPAN];
    logic signed [P_W-1:0]    prod      [KERNEL];
    logic signed [W_W-1:0]    w_q       [KERNEL];
    logic signed [W_W-1:0]    bias_q;

    // Products use the registered weights, so a same-cycle write only affects later samples.
    always_comb begin
        for (int k = 0; k < KERNEL; k++) begin
            prod[k] = P_W'(in_data) * P_W'(w_q[k]);
        end
        for (int j = 0; j < SPAN; j++) begin
            acc_d[j] = acc_q[j];
        end
        for (int k = 0; k < KERNEL; k++) begin
            acc_d[k*DILATION] = acc_q[k*DILATION] + ACC_W'(prod[k]);
        end
        for (int j = 0; j < SPAN - 1; j++) begin
            acc_shift[j] = acc_q[j+1];
        end
        acc_shift[SPAN-1] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KERNEL; k++) begin
                w_q[k] <= '0;
            end
            bias_q <= '0;
        end else if (w_we) begin
            for (int k = 0; k < KERNEL; k++) begin
                if (w_addr == AW'(k)) begin
                    w_q[k] <= w_data;
                end
            end
            if (HAS_BIAS != 0 && w_addr == AW'(KERNEL)) begin
                bias_q <= w_data;
            end
        end
    end

    // NOTE: the accumulator array is reset explicitly because a new frame must start from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            for (int j = 0; j < SPAN; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        last_q  <= in_last;
                        cnt_q   <= CNT_W'(STRIDE);
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        acc_q <= acc_shift;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            if (last_q && !EXACT) begin
                                cnt_q   <= CNT_W'(SPAN - STRIDE);
                                state_q <= FLUSH;
                            end else begin
                                last_q  <= 1'b0;
                                state_q <= ACCEPT;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        acc_q <= acc_shift;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            last_q  <= 1'b0;
                            state_q <= ACCEPT;
                        end
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCEPT);
    assign busy      = (state_q != ACCEPT);
    assign out_valid = (state_q != ACCEPT);
    assign out_data  = acc_q[0] + ((HAS_BIAS != 0) ? ACC_W'(bias_q) : '0);
    assign out_last  = (cnt_q == CNT_W'(1)) &&
                       ((state_q == FLUSH) || (state_q == EMIT && last_q && EXACT));
endmodule

// File: tb/tb_conv_transposed_1d_dilated_stream.sv
// Scoreboard bench: a direct-formula model queues expected outputs per frame and
// a negedge monitor pops and compares them on every output handshake.
module tb_conv_transposed_1d_dilated_stream;
    localparam int DATA_W = 16;
    localparam int W_W    = 16;
    localparam int ACC_W  = 40;
    localparam int K      = 3;
    localparam int S      = 2;
    localparam int D      = 2;
    localparam int SPAN   = D * (K - 1) + 1;
    localparam int AW     = $clog2(K + 1);

    typedef struct packed {
        logic signed [ACC_W-1:0] data;
        logic                    last;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     in_last = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_last;
    logic                     w_we = 1'b0;
    logic [AW-1:0]            w_addr = '0;
    logic signed [W_W-1:0]    w_data = '0;
    logic                     busy;

    conv_transposed_1d_dilated_stream #(
        .DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W), .KERNEL(K),
        .STRIDE(S), .DILATION(D), .HAS_BIAS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    exp_t   sb[$];
    longint w_m[K];
    longint bias_m = 0;
    bit     bp_mode = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // out_ready follows the 1-0-0-1 stall pattern while backpressure mode is on.
    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = pat[ph % 4];
                ph++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    logic                    stall_prev = 1'b0;
    logic signed [ACC_W-1:0] hold_data;
    logic                    hold_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", out_data, hold_data);
                check("hold_last", out_last, hold_last);
            end
            if (out_valid) check("in_ready_low_while_busy", in_ready, 0);
            if (out_valid && out_ready) begin
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            hold_last  = out_last;
        end
    end

    task automatic push_frame(input int xs[$]);
        int     len;
        longint y[];
        exp_t   e;
        len = (xs.size() - 1) * S + SPAN;
        y = new[len];
        for (int n = 0; n < len; n++) y[n] = bias_m;
        for (int i = 0; i < xs.size(); i++)
            for (int k = 0; k < K; k++)
                y[i*S + k*D] += longint'(xs[i]) * w_m[k];
        for (int n = 0; n < len; n++) begin
            e.data = y[n][ACC_W-1:0];
            e.last = (n == len - 1);
            sb.push_back(e);
        end
    endtask

    task automatic write_w(input int addr, input longint val);
        w_we   = 1'b1;
        w_addr = AW'(addr);
        w_data = W_W'(val);
        @(posedge clk);
        #1;
        w_we = 1'b0;
        if (addr < K) w_m[addr] = val;
        else bias_m = val;
    endtask

    task automatic drive_frame(input int xs[$]);
        int t;
        push_frame(xs);
        for (int i = 0; i < xs.size(); i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(xs[i]);
            in_last  = (i == xs.size() - 1);
            t = 0;
            while (!in_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("in_ready_seen", in_ready, 1);
            @(posedge clk);
            #1;
            check("first_out_latency", out_valid, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", (sb.size() == 0) && !out_valid, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t;
        for (int k = 0; k < K; k++) w_m[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_out_data", out_data, 0);

        write_w(0, 1); write_w(1, 2); write_w(2, 3);

        // Basic frame, single-sample frame, then the basic frame under backpressure.
        drive_frame('{1, 2});
        drain();
        drive_frame('{5});
        drain();
        check_idle("after_single");
        bp_mode = 1'b1;
        drive_frame('{1, 2});
        drain();
        bp_mode = 1'b0;

        // Bias applied to every output, then removed.
        write_w(K, -1);
        drive_frame('{1, 2});
        drain();
        write_w(K, 0);

        // Weight write in the same cycle as acceptance: the sample sees the old w[0].
        push_frame('{1});
        in_valid = 1'b1; in_data = 16'sd1; in_last = 1'b1;
        w_we = 1'b1; w_addr = AW'(0); w_data = 16'sd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; w_we = 1'b0;
        w_m[0] = 4;
        check("wupd_latency", out_valid, 1);
        drain();
        drive_frame('{1});
        drain();

        // Reset in FLUSH right after the value 7 has been taken.
        write_w(0, 1);
        drive_frame('{1, 2});
        t = 0;
        while (sb.size() > 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reached_flush", sb.size(), 2);
        check("in_flush_busy", busy, 1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check_idle("midreset");
        rst = 1'b0;
        for (int k = 0; k < K; k++) w_m[k] = 0;
        bias_m = 0;
        write_w(0, 1); write_w(1, 2); write_w(2, 3);
        drive_frame('{1});
        drain();
        check_idle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
